// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input,
// publishes results over valid/ready and flags stuck-high/stuck-low inputs.
module pwm_capture #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             stuck_high,
  output logic             stuck_low,
  output logic             overrun
);
  typedef enum logic {IDLE, MEASURE} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state;
  logic s1, lvl, lvl_d;
  logic [CNT_W-1:0] p_acc, h_acc, quiet;
  logic rise, fall, any_edge, publish;
  assign rise     = lvl & ~lvl_d;
  assign fall     = ~lvl & lvl_d;
  assign any_edge = rise | fall;
  assign publish  = enable && state == MEASURE && rise;
  always_ff @(posedge clock) begin
    if (reset) begin
      s1    <= 1'b0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      s1    <= pwm_in;
      lvl   <= s1;
      lvl_d <= lvl;
    end
  end
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      state      <= IDLE;
      p_acc      <= '0;
      h_acc      <= '0;
      quiet      <= '0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      quiet <= any_edge ? '0 : (quiet == TO ? quiet : quiet + 1'b1);
      if (any_edge) begin
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
      end else if (quiet == TO) begin
        stuck_high <= lvl;
        stuck_low  <= ~lvl;
      end
      if (!any_edge && quiet == TO) begin
        state <= IDLE;
      end else if (rise) begin
        state <= MEASURE;
        p_acc <= ONE;
        h_acc <= ONE;
      end else if (state == MEASURE) begin
        p_acc <= p_acc == MAX ? p_acc : p_acc + 1'b1;
        h_acc <= (lvl && h_acc != MAX) ? h_acc + 1'b1 : h_acc;
      end
    end
  end
  // a result arriving while the previous one is still unaccepted is dropped
  always_ff @(posedge clock) begin
    if (reset) begin
      meas_valid <= 1'b0;
      high_cnt   <= '0;
      period_cnt <= '0;
      overrun    <= 1'b0;
    end else if (publish && (!meas_valid || meas_ready)) begin
      meas_valid <= 1'b1;
      high_cnt   <= h_acc;
      period_cnt <= p_acc;
    end else if (publish) begin
      overrun <= 1'b1;
    end else if (meas_valid && meas_ready) begin
      meas_valid <= 1'b0;
    end
  end
endmodule

// File: doc/pwm_capture.md
# pwm_capture

Downstream measurement stage for the PWM generator output. Samples an asynchronous `pwm_in` and measures the high time and period of each full PWM cycle in clock cycles. Publishes each result through a valid/ready handshake and flags stuck-high and stuck-low inputs. Used as a loopback checker and duty-cycle monitor behind the generator.

## Interface
- `CNT_W`, default 8: width of the measurement counters and outputs.
- `TIMEOUT`, default 255: quiet cycles with no edge before a stuck flag is raised. Must satisfy 2 ≤ TIMEOUT ≤ 2^CNT_W−1.
- `clock`  in  1: the only clock. All logic is on the rising edge.
- `reset`  in  1: synchronous, active-high. Clears all state and outputs.
- `enable`  in  1: measurement enable. Low forces IDLE.
- `pwm_in`  in  1: asynchronous PWM input.
- `meas_ready`  in  1: consumer accepts the result.
- `meas_valid`  out  1: result pending.
- `high_cnt`  out  CNT_W: high cycles of the last complete period.
- `period_cnt`  out  CNT_W: total cycles of the last complete period.
- `stuck_high`  out  1: input held high for TIMEOUT cycles.
- `stuck_low`  out  1: input held low for TIMEOUT cycles.
- `overrun`  out  1: sticky. A result was dropped.

## Operation
- Input path: 2-flop synchronizer feeds `lvl`. A third flop holds `lvl_d`.
  - rise = `lvl & ~lvl_d`; fall = `~lvl & lvl_d`.
- FSM has two states:
  - IDLE: waits for a rise. A partial first period is discarded. On a rise it loads `p_acc`=1 and `h_acc`=1, then goes to MEASURE.
  - MEASURE: with no rise this cycle, `p_acc`+=1 and `h_acc`+=1 when `lvl`=1.
    - Both accumulators saturate at 2^CNT_W−1 and never wrap.
    - On a rise: publish `period_cnt`=`p_acc` and `high_cnt`=`h_acc` (values before this cycle's update), reload both accumulators to 1, and stay in MEASURE.
- Quiet counter: counts cycles since the last rise or fall. It is cleared by any edge.
  - When it reaches TIMEOUT: set `stuck_high`=`lvl` and `stuck_low`=~`lvl`, then FSM → IDLE (no result is published).
  - The quiet counter holds at TIMEOUT. Both stuck flags clear on the next edge.
- Handshake:
  - `meas_valid` rises when a result is published. It stays high, with `high_cnt`/`period_cnt` stable, until a cycle with `meas_valid & meas_ready`.
  - New result while `meas_valid` is high and `meas_ready` is low: the new result is dropped, the old data is kept, and `overrun`←1.
  - New result in the same cycle as acceptance: the new data is loaded, `meas_valid` stays 1, and `overrun` is unchanged.
  - `overrun` clears only on `reset`.
- `enable`=0:
  - FSM → IDLE; accumulators and quiet counter are cleared; stuck flags are cleared.
  - A pending result and `overrun` are retained, and the handshake still completes.
- `reset` mid-measurement: everything returns to its reset value next cycle, including the synchronizer. A pending result is lost.

## Timing
- Reset values: `meas_valid`=0, `high_cnt`=0, `period_cnt`=0, `stuck_high`=0, `stuck_low`=0, `overrun`=0. FSM=IDLE.
- Input latency: a `pwm_in` rise sampled at edge n appears as a rise at edge n+2.
- Result latency: `meas_valid` goes high one cycle after the rise that closes the period, so 3 cycles after the sampled `pwm_in` rise.
- Throughput: one result per PWM period. Minimum measurable period is 2 cycles (1 high, 1 low).
- A stuck flag asserts one cycle after the quiet counter reaches TIMEOUT.

## Test plan
- Steady PWM, 2 high / 30 low, `meas_ready`=1. The first period is discarded; every later period gives `high_cnt`=2, `period_cnt`=32 with a 1-cycle `meas_valid` pulse; `overrun`=0.
- Duty change from 2/32 to 16/32 mid-stream: the first full period after the change reports `high_cnt`=16, `period_cnt`=32. No mixed values appear.
- `pwm_in` held high for 300 cycles, TIMEOUT=255:
  - `stuck_high`=1 after 255 quiet cycles, FSM in IDLE, no result.
  - The next fall clears the flag.
  - The following full period reports correctly.
- `meas_ready`=0 for 3 periods of 4/10:
  - The first result is held stable with `meas_valid`=1, and `overrun`=1 after the second completion.
  - On `meas_ready`=1 the held result is accepted and `meas_valid` drops.
- 200 high / 200 low with CNT_W=8, TIMEOUT=255: `high_cnt`=200 and `period_cnt`=255 (saturated); no stuck flag.
- `reset` asserted for 1 cycle mid-period, then `enable` toggled low for 5 cycles:
  - All outputs are 0 after reset.
  - After re-enable, the first partial period is discarded and the next full period is correct.
